cachectl_mb: RTL

- Parametrised successor to the single-word cache stall controller.
- Explicit FSM; multi-beat line refill on read miss; write-through, no-write-allocate stores with a memory handshake; saturating hit/miss performance counters.
- Sits between the pipeline hazard logic (MemRead/MemWrite, stall) and the cache data array plus the external memory port.
- All state updates on posedge clk; no negedge or async-edge logic.

---
 rtl/cachectl_mb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cachectl_mb.sv
// Cache stall controller with multi-beat line refill on read miss and
// write-through, no-write-allocate stores; saturating hit/miss counters.
//
// state  | meaning
// IDLE   | evaluate pipeline request; hits pass through without stalling
// REFILL | fetch line one word per MemAck, valid set on the last beat
// WSTORE | write-through to memory; cache word updated only if it hit
module cachectl_mb #(
  parameter int WORDS_PER_LINE = 4,
  parameter int BEAT_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              CacheHit,
  input  logic              MemAck,
  output logic              stall,
  output logic              MemReq,
  output logic              MemWe,
  output logic [BEAT_W-1:0] BeatIdx,
  output logic              CacheWrite,
  output logic              CacheValidSet,
  output logic [CNT_W-1:0]  HitCount,
  output logic [CNT_W-1:0]  MissCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WSTORE = 2'd2
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               hitlatch_q, hitlatch_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // MemReq/MemWe are decoded from state only so they never glitch on MemAck.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    hitlatch_d    = hitlatch_q;
    stall         = 1'b0;
    MemReq        = 1'b0;
    MemWe         = 1'b0;
    BeatIdx       = '0;
    CacheWrite    = 1'b0;
    CacheValidSet = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          stall      = 1'b1;
          hitlatch_d = CacheHit;
          state_d    = WSTORE;
        end else if (MemRead) begin
          if (CacheHit) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            stall      = 1'b1;
            miss_cnt_d = sat_inc(miss_cnt_q);
            beat_d     = '0;
            state_d    = REFILL;
          end
        end
      end

      REFILL: begin
        stall   = 1'b1;
        MemReq  = 1'b1;
        BeatIdx = beat_q;
        if (MemAck) begin
          CacheWrite = 1'b1;
          if (beat_q == LAST_BEAT) begin
            CacheValidSet = 1'b1;
            beat_d        = '0;
            state_d       = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      WSTORE: begin
        stall  = 1'b1;
        MemReq = 1'b1;
        MemWe  = 1'b1;
        if (MemAck) begin
          CacheWrite = hitlatch_q;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      hitlatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      hitlatch_q <= hitlatch_d;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

endmodule
